// File: rtl/prime_pkg.sv
// Shared definitions for the prime-number blocks: default data width and
// the state encoding of the range scanner.
package prime_pkg;

    localparam int W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STALL,
        FINISH
    } scan_state_t;

endpackage

// File: rtl/prime_fifo.sv
// Small synchronous FIFO holding primes found by the scanner until the
// downstream consumer takes them. Head is forced to zero while empty so the
// stream data output has a defined value out of reset.
module prime_fifo
    import prime_pkg::*;
#(
    parameter int W          = W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [FIFO_DEPTH];

    // Read/write pointer update; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write.
    // NOTE: the array is deliberately not reset; entries are only observable
    // once written, and an unreset memory maps onto plain RAM/registers.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign head  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/prime_range_scanner.sv
// Walks an inclusive candidate range, issuing one start per candidate to the
// single-number prime checker, and queues the primes it reports (ascending)
// into a FIFO that drains on a valid/ready stream.
module prime_range_scanner
    import prime_pkg::*;
#(
    parameter int W          = W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] cfg_lo,
    input  logic [W-1:0] cfg_hi,
    output logic         busy,
    output logic         scan_done,
    output logic [W-1:0] prime_count,
    output logic         chk_start,
    output logic [W-1:0] chk_num,
    input  logic         chk_done,
    input  logic         chk_is_prime,
    output logic         p_valid,
    output logic [W-1:0] p_data,
    input  logic         p_ready
);

    localparam logic [W-1:0] W_ONE = {{(W-1){1'b0}}, 1'b1};

    scan_state_t  r_state;
    logic [W-1:0] r_cur;
    logic [W-1:0] r_hi;
    logic         r_busy;
    logic         r_scan_done;
    logic [W-1:0] r_prime_count;
    logic         r_chk_start;
    logic [W-1:0] r_chk_num;

    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_push;
    logic         w_advance;
    logic         w_release;

    assign w_pop = !w_empty && p_ready;

    // A stalled prime may enter the FIFO in the same cycle the head leaves it.
    assign w_release = (r_state == STALL) && (!w_full || w_pop);

    assign w_push    = ((r_state == WAIT) && chk_done && chk_is_prime && !w_full) ||
                       w_release;

    // Verdict fully consumed this cycle: move to the next candidate or finish.
    assign w_advance = ((r_state == WAIT) && chk_done && !(chk_is_prime && w_full)) ||
                       w_release;

    // Scan sequencer with registered checker handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cur         <= '0;
            r_hi          <= '0;
            r_busy        <= 1'b0;
            r_scan_done   <= 1'b0;
            r_prime_count <= '0;
            r_chk_start   <= 1'b0;
            r_chk_num     <= '0;
        end else begin
            r_scan_done <= 1'b0;
            r_chk_start <= 1'b0;

            if (w_push && (r_prime_count != '1)) begin
                r_prime_count <= r_prime_count + W_ONE;
            end

            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_hi          <= cfg_hi;
                        r_cur         <= cfg_lo;
                        r_prime_count <= '0;
                        if (cfg_lo > cfg_hi) begin
                            r_state     <= FINISH;
                            r_scan_done <= 1'b1;
                        end else begin
                            r_state     <= ISSUE;
                            r_busy      <= 1'b1;
                            r_chk_start <= 1'b1;
                            r_chk_num   <= cfg_lo;
                        end
                    end
                end

                ISSUE: begin
                    r_state <= WAIT;
                end

                WAIT, STALL: begin
                    if (w_advance) begin
                        // Compare before incrementing so hi = all-ones never wraps.
                        if (r_cur == r_hi) begin
                            r_state     <= FINISH;
                            r_busy      <= 1'b0;
                            r_scan_done <= 1'b1;
                        end else begin
                            r_state     <= ISSUE;
                            r_cur       <= r_cur + W_ONE;
                            r_chk_num   <= r_cur + W_ONE;
                            r_chk_start <= 1'b1;
                        end
                    end else if ((r_state == WAIT) && chk_done) begin
                        r_state <= STALL;
                    end
                end

                FINISH: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    prime_fifo #(
        .W          (W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_cur),
        .full  (w_full),
        .empty (w_empty),
        .head  (p_data)
    );

    assign busy        = r_busy;
    assign scan_done   = r_scan_done;
    assign prime_count = r_prime_count;
    assign chk_start   = r_chk_start;
    assign chk_num     = r_chk_num;
    assign p_valid     = !w_empty;

endmodule
